// File: rtl/id_ex_register.sv
// ID/EX pipeline register for the five-stage RV32 core: captures decoded fields,
// inserts NOPs on flush or load-use bubble, holds on stall, and counts NOP events.
module id_ex_register #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              bubble_i,
   input  logic [7:0]        ID_Control_i,
   input  logic [DATA_W-1:0] ID_PC_i,
   input  logic [DATA_W-1:0] ID_RS1data_i,
   input  logic [DATA_W-1:0] ID_RS2data_i,
   input  logic [DATA_W-1:0] ID_Imm_i,
   input  logic [9:0]        ID_Funct_i,
   input  logic [4:0]        ID_RS1addr_i,
   input  logic [4:0]        ID_RS2addr_i,
   input  logic [4:0]        ID_RDaddr_i,
   output logic [7:0]        EX_Control_o,
   output logic [DATA_W-1:0] EX_PC_o,
   output logic [DATA_W-1:0] EX_RS1data_o,
   output logic [DATA_W-1:0] EX_RS2data_o,
   output logic [DATA_W-1:0] EX_Imm_o,
   output logic [9:0]        EX_Funct_o,
   output logic [4:0]        EX_RS1addr_o,
   output logic [4:0]        EX_RS2addr_o,
   output logic [4:0]        EX_RDaddr_o,
   output logic              EX_Valid_o,
   output logic [CNT_W-1:0]  bubble_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);

   logic load_nop;

   // Flush and bubble both clear the slot; flush wins for counting purposes.
   assign load_nop = flush_i | bubble_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         EX_Control_o <= '0;
         EX_PC_o      <= '0;
         EX_RS1data_o <= '0;
         EX_RS2data_o <= '0;
         EX_Imm_o     <= '0;
         EX_Funct_o   <= '0;
         EX_RS1addr_o <= '0;
         EX_RS2addr_o <= '0;
         EX_RDaddr_o  <= '0;
         EX_Valid_o   <= 1'b0;
         bubble_cnt_o <= '0;
         flush_cnt_o  <= '0;
      end else if (!stall_i) begin
         if (load_nop) begin
            // Zero RD keeps the hazard unit and forwarding from matching a NOP.
            EX_Control_o <= '0;
            EX_PC_o      <= '0;
            EX_RS1data_o <= '0;
            EX_RS2data_o <= '0;
            EX_Imm_o     <= '0;
            EX_Funct_o   <= '0;
            EX_RS1addr_o <= '0;
            EX_RS2addr_o <= '0;
            EX_RDaddr_o  <= '0;
            EX_Valid_o   <= 1'b0;
         end else begin
            EX_Control_o <= ID_Control_i;
            EX_PC_o      <= ID_PC_i;
            EX_RS1data_o <= ID_RS1data_i;
            EX_RS2data_o <= ID_RS2data_i;
            EX_Imm_o     <= ID_Imm_i;
            EX_Funct_o   <= ID_Funct_i;
            EX_RS1addr_o <= ID_RS1addr_i;
            EX_RS2addr_o <= ID_RS2addr_i;
            EX_RDaddr_o  <= ID_RDaddr_i;
            EX_Valid_o   <= 1'b1;
         end

         if (flush_i) begin
            if (flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
         end else if (bubble_i) begin
            if (bubble_cnt_o != '1) bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/id_ex_register.md
# id_ex_register

Pipeline register between the ID and EX stages of the five-stage RV32 pipelined CPU. Each cycle it captures decoded control, operand data, immediate, function bits and register addresses. When the hazard detection unit requests a bubble it loads a NOP (all control cleared). It also honours a global stall (hold) and a branch flush, and keeps saturating bubble/flush event counters for performance debug. Its EX-side control and RD address outputs feed back to the hazard detection unit.

## Interface
- DATA_W, 32, width of PC, operand and immediate fields
- CNT_W, 16, width of each event counter

- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- stall_i  in  1  global stall; register holds all contents
- flush_i  in  1  branch-taken flush from ID; load a NOP
- bubble_i  in  1  load-use bubble request from the hazard detection unit; load a NOP
- ID_Control_i  in  8  [0] RegWrite, [1] MemtoReg, [2] MemRead, [3] MemWrite, [4] ALUSrc, [6:5] ALUOp, [7] reserved (registered as-is)
- ID_PC_i  in  DATA_W  PC of the ID instruction
- ID_RS1data_i, ID_RS2data_i  in  DATA_W  register file read data
- ID_Imm_i  in  DATA_W  sign-extended immediate
- ID_Funct_i  in  10  {funct7, funct3}
- ID_RS1addr_i, ID_RS2addr_i, ID_RDaddr_i  in  5 each  register addresses
- EX_Control_o  out  8  registered control; bits [4:0] feed the hazard detection unit
- EX_PC_o, EX_RS1data_o, EX_RS2data_o, EX_Imm_o  out  DATA_W  registered copies
- EX_Funct_o  out  10  registered copy
- EX_RS1addr_o, EX_RS2addr_o, EX_RDaddr_o  out  5 each  registered copies
- EX_Valid_o  out  1  1 = the EX slot holds a real instruction, 0 = NOP
- bubble_cnt_o  out  CNT_W  cycles in which a bubble was inserted because of bubble_i
- flush_cnt_o  out  CNT_W  cycles in which a NOP was inserted because of flush_i

## Operation
- Each rising edge applies exactly one action. Priority, highest first:
  1. rst_i: all outputs and counters go to 0, including EX_Valid_o.
  2. stall_i: hold every register. Counters do not change. A flush_i or bubble_i in this cycle is ignored; upstream holds its request until stall_i drops.
  3. flush_i: load a NOP and increment flush_cnt.
  4. bubble_i: load a NOP and increment bubble_cnt.
  5. Otherwise: load every ID_* input into the matching EX_* output and set EX_Valid_o = 1.
- NOP load: every EX_* data, address, control and funct field becomes 0, and EX_Valid_o = 0.
  - EX_RDaddr_o = 0 means no forwarding match downstream and no false hazard in the hazard detection unit.
- If flush_i and bubble_i are both high, only flush_cnt increments.
- Counters saturate at 2^CNT_W - 1 and do not wrap.
- No combinational path from any input to any output.

## Timing
- Latency: 1 cycle from ID_* inputs to EX_* outputs.
- Load-use sequence: a load is in EX and the dependent instruction is in ID at edge N, so bubble_i = 1.
  - After edge N: NOP in EX.
  - PC and IF/ID hold, so the dependent instruction is presented again and loads at edge N+1.
- bubble_i is combinational from this block's own outputs. The loop is broken by the register: on the cycle after the bubble, EX_Control_o[2] = 0, so bubble_i deasserts.
- A stall lasting k cycles holds the outputs unchanged for k edges. The first edge with stall_i low applies the normal priority.
- Reset mid-stream: the edge with rst_i high clears everything regardless of the other inputs. The next edge with rst_i low loads normally.

## Test plan
- Reset: drive random ID_* with rst_i = 1 for 2 cycles -> every output, both counters and EX_Valid_o are 0. After release, ID_RDaddr_i = 5, ID_Control_i = 8'h01 -> next cycle EX_RDaddr_o = 5, EX_Control_o = 8'h01, EX_Valid_o = 1.
- Load-use: EX holds a load (EX_Control_o = 8'h05, EX_RDaddr_o = 7), bubble_i = 1 for one edge -> EX_Control_o = 0, EX_RDaddr_o = 0, EX_Valid_o = 0, bubble_cnt_o = 1. Next edge loads ID_PC_i = 32'h0000_0010 -> EX_PC_o = 32'h10.
- Stall hold: EX_Imm_o = 32'hFFFF_FFF0, then stall_i = 1 for 3 cycles while bubble_i = 1 and ID_* change -> outputs unchanged and bubble_cnt_o unchanged throughout. Fourth edge: bubble applies.
- Flush vs bubble: flush_i = 1 and bubble_i = 1 on the same edge -> NOP loaded, flush_cnt_o +1, bubble_cnt_o unchanged.
- Saturation: with CNT_W = 4, 20 consecutive bubble edges -> bubble_cnt_o stops at 15.
- Reset during stall: stall_i = 1 and rst_i = 1 -> all outputs 0 on that edge.
